// File: rtl/ov7670_fb_writer.sv
// Purpose: converts the OV7670 RGB565 byte stream (vsync/href/byte pairs) into frame-buffer pixel writes.
// Latency: the write pulse (we, wAddr, wData) is registered 1 cycle after the second byte of a pixel.
// Backpressure: none; the camera cannot be stalled, so excess bytes or lines are dropped without writing.
module ov7670_fb_writer #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  cam_data,
    output logic        we,
    output logic [16:0] wAddr,
    output logic [15:0] wData,
    output logic        frame_done
);

    localparam int PW = $clog2(H_PIX + 1);
    localparam int LW = $clog2(V_LINES + 1);

    localparam logic [PW-1:0] PIX_MAX   = PW'(H_PIX);
    localparam logic [LW-1:0] LINE_MAX  = LW'(V_LINES);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);
    localparam logic [16:0]   ADDR_STEP = 17'(H_PIX);

    typedef enum logic [1:0] {
        WAIT_VS    = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [16:0]   line_base;
    logic          phase;
    logic [7:0]    high_byte;
    logic          href_q;

    logic          clr_cnt;
    logic          do_toggle;
    logic          do_latch;
    logic          do_write;
    logic          line_end;
    logic          line_inc;
    logic          frame_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        do_toggle = 1'b0;
        do_latch  = 1'b0;
        do_write  = 1'b0;
        line_end  = 1'b0;
        line_inc  = 1'b0;
        frame_end = 1'b0;
        case (state)
            WAIT_VS: begin
                if (vsync) begin
                    state_nxt = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (!vsync) begin
                    state_nxt = CAPTURE;
                    clr_cnt   = 1'b1;
                end
            end
            CAPTURE: begin
                if (vsync) begin
                    // vsync before the last line means the frame is incomplete: drop it
                    state_nxt = WAIT_FRAME;
                    clr_cnt   = 1'b1;
                end else if (href) begin
                    do_toggle = 1'b1;
                    if (!phase) begin
                        do_latch = 1'b1;
                    end else if ((pix_cnt < PIX_MAX) && (line_cnt < LINE_MAX)) begin
                        do_write = 1'b1;
                    end
                end else if (href_q) begin
                    line_end = 1'b1;
                    // pix_cnt only advances on a write, so non-zero means the line produced pixels
                    if (pix_cnt != '0) begin
                        line_inc = 1'b1;
                        if (line_cnt == LINE_LAST) begin
                            frame_end = 1'b1;
                            state_nxt = WAIT_VS;
                        end
                    end
                end
            end
            default: begin
                state_nxt = WAIT_VS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            high_byte  <= '0;
            href_q     <= 1'b0;
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            frame_done <= 1'b0;
        end else begin
            href_q     <= href;
            we         <= do_write;
            frame_done <= frame_end;

            if (do_toggle) begin
                phase <= ~phase;
            end
            if (do_latch) begin
                high_byte <= cam_data;
            end
            if (do_write) begin
                wData   <= {high_byte, cam_data};
                wAddr   <= line_base + 17'(pix_cnt);
                pix_cnt <= pix_cnt + PW'(1);
            end

            // a lone high byte is dropped here simply by resetting the phase
            if (line_end) begin
                pix_cnt <= '0;
                phase   <= 1'b0;
                if (line_inc) begin
                    line_cnt  <= line_cnt + LW'(1);
                    line_base <= line_base + ADDR_STEP;
                end
            end

            if (clr_cnt) begin
                pix_cnt   <= '0;
                line_cnt  <= '0;
                line_base <= '0;
                phase     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ov7670_fb_writer.md
OV7670_FB_WRITER -- requirements
Module: ov7670_fb_writer

Interface
REQ-001 SHALL have parameter H_PIX, default 320, pixels per line written to the frame buffer.
REQ-002 SHALL have parameter V_LINES, default 240, lines per frame written to the frame buffer.
REQ-003 SHALL have port clk  input  1  single clock (camera PCLK domain); all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port vsync  input  1  camera frame sync, high = vertical blanking.
REQ-006 SHALL have port href  input  1  camera line valid, high = data bytes valid.
REQ-007 SHALL have port cam_data  input  8  camera byte bus, RGB565 high byte first.
REQ-008 SHALL have port we  output  1  frame buffer write enable, one-cycle pulse per pixel.
REQ-009 SHALL have port wAddr  output  17  frame buffer write address = H_PIX*line + pixel.
REQ-010 SHALL have port wData  output  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a complete frame.

Function
REQ-012 SHALL implement states WAIT_VS, WAIT_FRAME, CAPTURE.
REQ-013 WAIT_VS SHALL move to WAIT_FRAME when vsync is sampled high.
REQ-014 WAIT_FRAME SHALL move to CAPTURE on the first cycle vsync is sampled low; line and pixel counters cleared.
REQ-015 In CAPTURE, each cycle with href high SHALL toggle a byte-phase bit; phase 0 latches cam_data as high byte, phase 1 forms the pixel.
REQ-016 On phase 1, SHALL register wData = {high_byte, cam_data}, wAddr = H_PIX*line + pixel, and assert we for exactly the next cycle (latency 1 cycle from second byte).
REQ-017 Pixel counter SHALL increment after each write and SHALL saturate: bytes beyond H_PIX pixels on a line SHALL produce no write.
REQ-018 Falling edge of href (high to low between consecutive samples) SHALL clear pixel counter and byte phase, and increment line counter if at least one pixel was written on that line.
REQ-019 A lone high byte left by href dropping SHALL be discarded, with no write.
REQ-020 Lines beyond V_LINES SHALL produce no write; wAddr SHALL never exceed H_PIX*V_LINES-1 (76799 default).
REQ-021 When the line counter reaches V_LINES, SHALL pulse frame_done for one cycle and return to WAIT_VS.
REQ-022 vsync sampled high during CAPTURE before V_LINES lines SHALL abort the frame: no frame_done, counters cleared, state WAIT_FRAME.
REQ-023 Address arithmetic SHALL be 17-bit unsigned with no overflow for the default parameters.
REQ-024 we SHALL be low in WAIT_VS and WAIT_FRAME; wData and wAddr SHALL hold their last values when we is low.

Reset
REQ-025 reset_n low SHALL asynchronously force state WAIT_VS, we=0, frame_done=0, wAddr=0, wData=0, counters and byte phase 0.
REQ-026 Reset asserted mid-frame SHALL discard the frame; after release, capture SHALL resume only after a full vsync high-then-low sequence.

Verification
REQ-027 Release reset, vsync 1->0, one href line of bytes 0xF8,0x1F repeated 320 times -> 320 we pulses, wAddr 0..319, wData 0xF81F each.
REQ-028 Full frame 240 lines x 640 bytes -> last write wAddr=76799, frame_done pulses once after it, state WAIT_VS.
REQ-029 Line with 645 bytes (odd, overlong) -> exactly 320 writes, no address above line base+319, next line starts at base+320.
REQ-030 href drops after 3 bytes -> one write only; next line begins at pixel 0 of line+1.
REQ-031 vsync rises after 100 lines -> no frame_done; next frame's first write at wAddr=0.
REQ-032 reset_n pulsed low at line 50 -> all outputs 0 immediately; no write until the next vsync high-low.
